// File: rtl/fixed_att_residual_add.sv
// ---------------------------------------------------------------------------
// fixed_att_residual_add
//
// Residual-connection stage behind the fixed-point self-attention block.
// Every block that enters attention is also pushed into a small residual
// FIFO. When the matching attention output block arrives, the oldest stored
// residual block is popped. It is added element-wise to the attention block,
// with saturation, and the sum is captured in a registered output stage.
//
// Handshake rule for every port pair: a transfer happens on a rising clk
// edge where valid && ready are both high. A producer may not retract valid
// or change data until that transfer has happened.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous, active-low reset
//   data_in          residual block, PARALLELISM*SIZE elements, element r*SIZE+c
//   data_in_valid    residual block valid
//   data_in_ready    residual FIFO has room (never depends on downstream)
//   att_in           attention output block
//   att_in_valid     attention block valid
//   att_in_ready     attention block is accepted this cycle if valid
//   data_out         saturated element-wise sum
//   data_out_valid   output register holds a block
//   data_out_ready   downstream accepts data_out
//   fifo_count       residual blocks currently stored (registered)
// ---------------------------------------------------------------------------
module fixed_att_residual_add #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_FRAC_WIDTH = 1,
  parameter int PARALLELISM     = 3,
  parameter int SIZE            = 3,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [DATA_WIDTH*PARALLELISM*SIZE-1:0]      data_in,
  input  logic                                        data_in_valid,
  output logic                                        data_in_ready,
  input  logic [DATA_WIDTH*PARALLELISM*SIZE-1:0]      att_in,
  input  logic                                        att_in_valid,
  output logic                                        att_in_ready,
  output logic [DATA_WIDTH*PARALLELISM*SIZE-1:0]      data_out,
  output logic                                        data_out_valid,
  input  logic                                        data_out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]             fifo_count
);

  localparam int NE = PARALLELISM * SIZE;
  localparam int BW = DATA_WIDTH * NE;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Both operands share DATA_FRAC_WIDTH, so the binary points already line
  // up and the add needs no shift or rounding.
  localparam int UNUSED_FRAC = DATA_FRAC_WIDTH;

  logic [BW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_data_out;
  logic          r_data_out_valid;

  logic          w_full;
  logic          w_empty;
  logic          w_out_free;
  logic          w_push;
  logic          w_fire;
  logic [BW-1:0] w_head;
  logic [BW-1:0] w_sum;

  assign w_full     = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_out_free = !r_data_out_valid || data_out_ready;

  // Ready is gated by rst so that nothing handshakes while reset is held.
  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign data_in_ready = rst && !w_full;
  assign att_in_ready  = rst && !w_empty && w_out_free;

  assign w_push = data_in_valid && data_in_ready;
  assign w_fire = att_in_valid && att_in_ready;

  assign w_head = r_mem[r_rp];

  // Element-wise add, one bit wider than the operands, then clamp to the
  // signed DATA_WIDTH range. The sum has overflowed when its two top bits
  // differ. The top bit is the true sign and selects the clamp direction.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NE; i++) begin
      logic [DATA_WIDTH:0] v_s;
      v_s = {att_in[i*DATA_WIDTH + DATA_WIDTH-1], att_in[i*DATA_WIDTH +: DATA_WIDTH]}
          + {w_head[i*DATA_WIDTH + DATA_WIDTH-1], w_head[i*DATA_WIDTH +: DATA_WIDTH]};
      if (v_s[DATA_WIDTH] != v_s[DATA_WIDTH-1]) begin
        w_sum[i*DATA_WIDTH +: DATA_WIDTH] = v_s[DATA_WIDTH]
          ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        w_sum[i*DATA_WIDTH +: DATA_WIDTH] = v_s[DATA_WIDTH-1:0];
      end
    end
  end

  // Storage is not reset. Whether an entry is live is decided by the
  // pointers and the count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= data_in;
  end

  // The pointers wrap explicitly, so depths that are not a power of two
  // still work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == PW'(FIFO_DEPTH-1)) ? '0 : r_wp + 1'b1;
      if (w_fire) r_rp <= (r_rp == PW'(FIFO_DEPTH-1)) ? '0 : r_rp + 1'b1;
      if (w_push && !w_fire)      r_cnt <= r_cnt + 1'b1;
      else if (w_fire && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // The output register loads on fire. Otherwise it holds its data. Valid
  // drops only once downstream has taken the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_data_out       <= w_sum;
      r_data_out_valid <= 1'b1;
    end else if (data_out_ready) begin
      r_data_out_valid <= 1'b0;
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign fifo_count     = r_cnt;

endmodule
